// File: rtl/keypad_input_unit.sv
// Scans a 4x4 active-low keypad, debounces presses and assembles hex digits into a value
// that is published to the CPU with a valid/read handshake. Define KEYPAD_ECHO_EN to add echo_data.
module keypad_input_unit #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int MAX_DIGITS      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   input  logic        input_enable,
   input  logic        cpu_read,
   output logic [31:0] read_data,
   output logic        key_valid
`ifdef KEYPAD_ECHO_EN
   ,
   output logic [31:0] echo_data
`endif
);

   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]        MAX_CNT   = 4'(MAX_DIGITS);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, ACTION, RELEASE} state_t;

   state_t            state;
   logic [SCAN_W-1:0] scan_cnt;
   logic [DEB_W-1:0]  deb_cnt;
   logic [1:0]        key_row;
   logic [1:0]        key_col;
   logic [3:0]        row_pat;
   logic [27:0]       acc;
   logic [3:0]        cnt;
   logic [27:0]       data;
   logic              valid;
   logic              overrun;

   logic [3:0] row_low;
   logic       one_row;
   logic [1:0] row_idx;
   logic [1:0] col_idx;
   logic [3:0] nibble;
   logic       is_back;
   logic       is_enter;
   logic       commit;

   assign row_low = ~row_in;
   assign one_row = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);

   always_comb begin
      row_idx = 2'd0;
      case (row_low)
         4'b0010: row_idx = 2'd1;
         4'b0100: row_idx = 2'd2;
         4'b1000: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
      col_idx = 2'd0;
      case (col_out)
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   // Column 3 holds A-D, row 3 holds *,0,#,D; the remaining 3x3 block is 1..9 in reading order.
   always_comb begin
      nibble   = 4'd0;
      is_back  = 1'b0;
      is_enter = 1'b0;
      if (key_col == 2'd3) begin
         nibble = 4'hA + {2'b00, key_row};
      end else if (key_row == 2'd3) begin
         case (key_col)
            2'd0:    is_back  = 1'b1;
            2'd1:    nibble   = 4'd0;
            default: is_enter = 1'b1;
         endcase
      end else begin
         nibble = {key_row, 2'b00} - {2'b00, key_row} + {2'b00, key_col} + 4'd1;
      end
   end

   assign commit = (state == ACTION) && input_enable && is_enter;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SCAN;
         col_out  <= 4'b1110;
         scan_cnt <= '0;
         deb_cnt  <= '0;
         key_row  <= 2'd0;
         key_col  <= 2'd0;
         row_pat  <= 4'hF;
         acc      <= '0;
         cnt      <= 4'd0;
         data     <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         case (state)
            SCAN: begin
               if (scan_cnt == SCAN_LAST) begin
                  scan_cnt <= '0;
                  if (one_row) begin
                     key_row <= row_idx;
                     key_col <= col_idx;
                     row_pat <= row_in;
                     deb_cnt <= '0;
                     state   <= DEBOUNCE;
                  end else begin
                     col_out <= {col_out[2:0], col_out[3]};
                  end
               end else begin
                  scan_cnt <= scan_cnt + SCAN_W'(1);
               end
            end
            DEBOUNCE: begin
               if (row_in != row_pat) begin
                  col_out  <= {col_out[2:0], col_out[3]};
                  scan_cnt <= '0;
                  state    <= SCAN;
               end else if (deb_cnt == DEB_LAST) begin
                  state <= ACTION;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            ACTION: begin
               if (input_enable) begin
                  if (is_enter) begin
                     acc <= '0;
                     cnt <= 4'd0;
                  end else if (is_back) begin
                     if (cnt != 4'd0) begin
                        acc <= acc >> 4;
                        cnt <= cnt - 4'd1;
                     end
                  end else if (cnt < MAX_CNT) begin
                     acc <= {acc[23:0], nibble};
                     cnt <= cnt + 4'd1;
                  end
               end
               deb_cnt <= '0;
               state   <= RELEASE;
            end
            RELEASE: begin
               if (row_in != 4'hF) begin
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  col_out  <= {col_out[2:0], col_out[3]};
                  scan_cnt <= '0;
                  state    <= SCAN;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            default: state <= SCAN;
         endcase

         // A commit that lands on an unread word flags overrun unless the CPU reads in that same cycle.
         if (commit) begin
            data    <= acc;
            valid   <= 1'b1;
            overrun <= valid && !cpu_read;
         end else if (cpu_read) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

   assign read_data = {valid, overrun, 2'b00, data};
   assign key_valid = valid;

`ifdef KEYPAD_ECHO_EN
   assign echo_data = {1'b0, cnt[2:0], acc};
`endif

endmodule

// File: tb/tb_keypad_input_unit.sv
// Self-checking bench for keypad_input_unit with a behavioural keypad matrix model.
// Builds with or without KEYPAD_ECHO_EN.
module tb_keypad_input_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic        input_enable;
   logic        cpu_read;
   logic [31:0] read_data;
   logic        key_valid;
`ifdef KEYPAD_ECHO_EN
   logic [31:0] echo_data;
`endif

   logic       key_down;
   logic [1:0] key_row;
   logic [1:0] key_col;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [95:0] keys;
      logic [31:0] exp_commit;
      logic [31:0] exp_read;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   // A held key shorts its row to the driven column only while that column is low.
   assign row_in = (key_down && (col_out[key_col] == 1'b0)) ? ~(4'b0001 << key_row) : 4'b1111;

   keypad_input_unit #(
      .SCAN_DIV(4),
      .DEBOUNCE_CYCLES(8),
      .MAX_DIGITS(7)
   ) dut (
      .clk(clk),
      .rst(rst),
      .row_in(row_in),
      .col_out(col_out),
      .input_enable(input_enable),
      .cpu_read(cpu_read),
      .read_data(read_data),
      .key_valid(key_valid)
`ifdef KEYPAD_ECHO_EN
      ,
      .echo_data(echo_data)
`endif
   );

   function automatic logic [3:0] key_pos(input logic [7:0] ch);
      case (ch)
         "1": return 4'h0;
         "2": return 4'h1;
         "3": return 4'h2;
         "A": return 4'h3;
         "4": return 4'h4;
         "5": return 4'h5;
         "6": return 4'h6;
         "B": return 4'h7;
         "7": return 4'h8;
         "8": return 4'h9;
         "9": return 4'hA;
         "C": return 4'hB;
         "*": return 4'hC;
         "0": return 4'hD;
         "#": return 4'hE;
         default: return 4'hF;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
      end
   endtask

   task automatic select_key(input logic [7:0] ch);
      logic [3:0] pos;
      pos = key_pos(ch);
      key_row = pos[3:2];
      key_col = pos[1:0];
   endtask

   task automatic applyStimulus(input logic [7:0] ch);
      select_key(ch);
      key_down = 1'b1;
      repeat (40) @(negedge clk);
      key_down = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic press_string(input logic [95:0] keys);
      logic [7:0] ch;
      for (int i = 11; i >= 0; i--) begin
         ch = keys[i*8 +: 8];
         if (ch != 8'd0) applyStimulus(ch);
      end
   endtask

   task automatic pulse_read();
      @(negedge clk);
      cpu_read = 1'b1;
      @(negedge clk);
      cpu_read = 1'b0;
   endtask

   // Waits (at a falling edge) until column 1 is driven, so the next column change is the one to column 2.
   task automatic wait_col1();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (col_out == 4'b1101) found = 1'b1;
      end
      checkOutput("wait col1", {31'b0, found}, 32'd1);
   endtask

   task automatic wait_col2_edge();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk);
         #1;
         if (col_out == 4'b1011) found = 1'b1;
      end
      checkOutput("wait col2", {31'b0, found}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{keys: "123#",       exp_commit: 32'h8000_0123, exp_read: 32'h0000_0123};
      vecs[1] = '{keys: "89*5#",      exp_commit: 32'h8000_0085, exp_read: 32'h0000_0085};
      vecs[2] = '{keys: "123456789#", exp_commit: 32'h8123_4567, exp_read: 32'h0123_4567};
      vecs[3] = '{keys: "#",          exp_commit: 32'h8000_0000, exp_read: 32'h0000_0000};
      vecs[4] = '{keys: "*5#",        exp_commit: 32'h8000_0005, exp_read: 32'h0000_0005};
      vecs[5] = '{keys: "ABCD0#",     exp_commit: 32'h800A_BCD0, exp_read: 32'h000A_BCD0};

      rst          = 1'b1;
      key_down     = 1'b0;
      key_row      = 2'd0;
      key_col      = 2'd0;
      input_enable = 1'b1;
      cpu_read     = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset col_out", {28'b0, col_out}, 32'h0000_000E);
      checkOutput("reset read_data", read_data, 32'h0);
      checkOutput("reset key_valid", {31'b0, key_valid}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         press_string(vecs[i].keys);
         checkOutput($sformatf("vec%0d commit", i), read_data, vecs[i].exp_commit);
         checkOutput($sformatf("vec%0d key_valid", i), {31'b0, key_valid}, {31'b0, vecs[i].exp_commit[31]});
         pulse_read();
         checkOutput($sformatf("vec%0d after read", i), read_data, vecs[i].exp_read);
      end

`ifdef KEYPAD_ECHO_EN
      press_string("89*5");
      checkOutput("echo before enter", echo_data, 32'h2000_0085);
      press_string("#");
      checkOutput("echo commit", read_data, 32'h8000_0085);
      checkOutput("echo cleared", echo_data, 32'h0);
      pulse_read();
`endif

      // Bounce on key 5: never stable long enough to be accepted.
      select_key("5");
      for (int i = 0; i < 10; i++) begin
         key_down = ~key_down;
         repeat (3) @(negedge clk);
      end
      key_down = 1'b0;
      repeat (40) @(negedge clk);
`ifdef KEYPAD_ECHO_EN
      checkOutput("bounce echo", echo_data, 32'h0);
`endif
      applyStimulus("7");
`ifdef KEYPAD_ECHO_EN
      checkOutput("after 7 echo", echo_data, 32'h1000_0007);
`endif
      press_string("#");
      checkOutput("bounce then 7", read_data, 32'h8000_0007);
      pulse_read();

      // Overrun, then a commit coinciding with cpu_read.
      press_string("4#");
      checkOutput("commit 4", read_data, 32'h8000_0004);
      press_string("5#");
      checkOutput("overrun 5", read_data, 32'hC000_0005);
      applyStimulus("6");
      select_key("#");
      wait_col1();
      key_down = 1'b1;
      wait_col2_edge();
      repeat (12) @(posedge clk);
      @(negedge clk);
      checkOutput("before enter 6", read_data, 32'hC000_0005);
      cpu_read = 1'b1;
      @(negedge clk);
      cpu_read = 1'b0;
      checkOutput("commit with read", read_data, 32'h8000_0006);
      repeat (40) @(negedge clk);
      key_down = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("hold no repeat", read_data, 32'h8000_0006);
      pulse_read();
      checkOutput("read 6", read_data, 32'h0000_0006);

      // input_enable gates effects but keeps the accumulator.
      press_string("4");
      input_enable = 1'b0;
      press_string("3#");
      checkOutput("disabled key_valid", {31'b0, key_valid}, 32'h0);
      checkOutput("disabled read_data", read_data, 32'h0000_0006);
      input_enable = 1'b1;
      press_string("#");
      checkOutput("reenabled commit", read_data, 32'h8000_0004);

      // Reset while debouncing key 3; the still-held key is picked up again afterwards.
      select_key("3");
      wait_col1();
      key_down = 1'b1;
      wait_col2_edge();
      repeat (6) @(posedge clk);
      #1;
      checkOutput("column frozen", {28'b0, col_out}, 32'h0000_000B);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid reset col_out", {28'b0, col_out}, 32'h0000_000E);
      checkOutput("mid reset read_data", read_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      key_down = 1'b0;
      repeat (40) @(negedge clk);
      press_string("#");
      checkOutput("held through reset", read_data, 32'h8000_0003);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
